syscall_handler: RTL and testbench
==================================

// Module: syscall_handler
// PURPOSE
//  System-side consumer of the CPU controller's syscall interface. Catches the one-cycle
//  syscall pulse with its sys_op/sys_inf_out, sleeps the CPU, then serves the request:
//  show a word on the display, read the switches on a debounced confirm key, or exit.
//  It then wakes the CPU and returns read data on sys_inf_in.
//  Same clock domain as the controller's clk (board clock, not the divided CPU clock).
// PARAMETERS
//  OP_W         4     syscall opcode width; equals `SYS_OP_LENGTH
//  HOLD_CYCLES  4096  clk cycles PRINT holds the CPU asleep; 0 is treated as 1
//  DEB_CYCLES   1000  clk cycles key_raw must stay stable before it is accepted
// PORTS
//  clk          in   1     system clock
//  rst          in   1     reset, asynchronous, active-low (0 = reset)
//  sysc_mp      in   1     one-cycle syscall pulse from the CPU controller
//  sys_op       in   OP_W  syscall opcode; valid in the cycle sysc_mp=1
//  sys_inf_out  in   32    CPU output word; valid in the cycle sysc_mp=1
//  sw           in   32    board switches, asynchronous
//  key_raw      in   1     confirm button, raw and asynchronous, active-high
//  cpu_slep     out  1     one-cycle sleep request to the CPU controller
//  cpu_wake     out  1     one-cycle wake request to the CPU controller
//  sys_inf_in   out  32    word returned to the CPU (READ result)
//  disp_data    out  32    word shown on the display
//  disp_valid   out  1     disp_data holds a printed value
//  busy         out  1     1 whenever state != IDLE
//  exit_flag    out  1     sticky; set by EXIT
//  err_flag     out  1     sticky; set by an unknown op or a syscall arriving while busy
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, hold counter=0; every output 0, including the sticky
//   flags. Reset mid-operation aborts the request with no wake pulse.
//  Opcodes (shared defines): PRINT=1, READ=2, EXIT=3; all other codes are unknown.
//  FSM states: IDLE, SLEEP, PRINT_HOLD, READ_WAIT, WAKE, HALTED.
//  IDLE: at edge E0 with sysc_mp=1, latch op and data.
//   - PRINT: also load disp_data=sys_inf_out and set disp_valid=1 at E0.
//   - Go to SLEEP. cpu_slep=1 for exactly the cycle after E0.
//  SLEEP (1 cycle), dispatch on the latched op:
//   - PRINT: go to PRINT_HOLD; counter=max(HOLD_CYCLES,1)-1.
//   - READ: go to READ_WAIT.
//   - EXIT: go to HALTED; exit_flag=1.
//   - unknown: go to WAKE; err_flag=1.
//  PRINT_HOLD: counter decrements each edge. At 0, go to WAKE.
//   disp_data/disp_valid stay held until the next PRINT or reset.
//  READ_WAIT: on a rising edge of key_db, sys_inf_in<=synchronised sw, then go to WAKE.
//   sys_inf_in holds until the next READ.
//  WAKE: cpu_wake=1 for one cycle, then IDLE.
//  HALTED: terminal; leave only by reset. cpu_wake is never asserted here.
//  cpu_slep and cpu_wake are registered and never high together. Each is a single-cycle
//   pulse (the controller gives wake priority over sleep).
//  sysc_mp while busy=1: ignored (op/data not latched, state unchanged); err_flag=1.
//  Latency: unknown op gives wake 2 cycles after E0. PRINT gives wake at
//   E0+2+max(HOLD_CYCLES,1).
//  sw: two-flop synchronised. key_raw: two-flop synchronised, then debounced, then
//   rising-edge detected.
//  Key pressed before READ_WAIT is entered does not count; a new rising edge is required.
// STRUCTURE
//  Shared header (alongside `SYS_OP_LENGTH): SYS_OP_PRINT/READ/EXIT defines and the
//   FSM state localparams.
//  Sub-module key_debounce #(DEB_CYCLES): clk, rst, in, out stable level.
//   - Contains the 2-flop sync and a saturating stability counter.
//   - Output changes only after DEB_CYCLES consecutive equal samples.
//  Top level holds the FSM, the hold counter, the sw sync, the key edge detect and the
//   output registers.
// TESTING (bench: HOLD_CYCLES=4, DEB_CYCLES=3)
//  1 Reset: rst=0 in any state -> every output 0 within the same cycle, busy=0.
//  2 PRINT: op=1, inf_out=0xDEADBEEF at E0 -> disp_data=0xDEADBEEF and disp_valid=1
//    after E0; cpu_slep in cycle E0+1; cpu_wake in cycle E0+6; busy=0 after.
//  3 READ: op=2, sw=0x0000A5A5; key bounces 2 cycles, then held 10 cycles
//    -> bounce ignored; sys_inf_in=0x0000A5A5 then a single cpu_wake.
//  4 EXIT: op=3 -> one cpu_slep; exit_flag=1; no cpu_wake for 100 cycles;
//    a further sysc_mp sets err_flag and changes nothing else.
//  5 Unknown op=7 -> cpu_slep at E0+1, cpu_wake at E0+2, err_flag=1.
//  6 sysc_mp during PRINT_HOLD -> err_flag=1, disp_data unchanged.
//    rst pulse during READ_WAIT -> clean IDLE; the next PRINT is served normally.

Source files
------------

// File: rtl/syscall_handler_pkg.sv
// Shared definitions for the syscall handler slice.
//  - SYS_OP_LENGTH : width of the syscall opcode field.
//  - SYS_OP_*      : opcodes the handler understands. Every other code is unknown.
//  - ST_*          : FSM state encodings. They are exposed on state_dbg.
package syscall_handler_pkg;

    localparam int SYS_OP_LENGTH = 4;

    localparam logic [SYS_OP_LENGTH-1:0] SYS_OP_PRINT = 4'd1;
    localparam logic [SYS_OP_LENGTH-1:0] SYS_OP_READ  = 4'd2;
    localparam logic [SYS_OP_LENGTH-1:0] SYS_OP_EXIT  = 4'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_SLEEP      = 3'd1;
    localparam state_t ST_PRINT_HOLD = 3'd2;
    localparam state_t ST_READ_WAIT  = 3'd3;
    localparam state_t ST_WAKE       = 3'd4;
    localparam state_t ST_HALTED     = 3'd5;

    // Reload value for the PRINT hold counter. A hold of 0 behaves like a hold of 1.
    function automatic int unsigned hold_load(input int unsigned hold_cycles);
        return (hold_cycles > 1) ? hold_cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/syscall_handler_if.sv
// Syscall link between the CPU controller (master) and the syscall handler (slave).
//  sysc_mp     master->slave  one-cycle request pulse
//  sys_op      master->slave  opcode, valid only while sysc_mp=1
//  sys_inf_out master->slave  CPU word, valid only while sysc_mp=1
//  cpu_slep    slave->master  one-cycle sleep request
//  cpu_wake    slave->master  one-cycle wake request
//  sys_inf_in  slave->master  READ result, stable from the wake pulse until the next READ
// Protocol: this link does not use a valid/ready pair. A request is the single cycle in
// which sysc_mp=1, and it has no back-pressure. The slave acknowledges with cpu_slep in
// the following cycle. It completes the request with cpu_wake. EXIT never completes.
// A request that arrives while the slave is busy is dropped and flagged as an error.
interface syscall_handler_if #(
    parameter int OP_W = 4
);
    logic            sysc_mp;
    logic [OP_W-1:0] sys_op;
    logic [31:0]     sys_inf_out;
    logic            cpu_slep;
    logic            cpu_wake;
    logic [31:0]     sys_inf_in;

    modport master (
        output sysc_mp, sys_op, sys_inf_out,
        input  cpu_slep, cpu_wake, sys_inf_in
    );

    modport slave (
        input  sysc_mp, sys_op, sys_inf_out,
        output cpu_slep, cpu_wake, sys_inf_in
    );
endinterface

// File: rtl/syscall_handler_key_debounce.sv
// key_debounce: synchronises an asynchronous level and filters out bounce.
//  clk  in  system clock
//  rst  in  asynchronous reset, active-low
//  in   in  raw asynchronous level
//  out  out debounced level. It changes only after DEB_CYCLES consecutive synchronised
//           samples that differ from the current out.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    // A setting of 0 behaves like 1: one differing sample is enough to change out.
    localparam int unsigned DEB_N = (DEB_CYCLES == 0) ? 1 : DEB_CYCLES;
    localparam int          CW    = (DEB_N > 1) ? $clog2(DEB_N + 1) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            out <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
            // cnt counts consecutive samples that disagree with out. A sample that
            // agrees with out restarts the count, so a short glitch never reaches the top.
            if (s2 == out) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_N - 1)) begin
                out <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/syscall_handler.sv
// syscall_handler: serves syscalls from the CPU controller.
// On a request it puts the CPU to sleep and serves it (PRINT / READ / EXIT).
// When the request is complete it wakes the CPU.
//  clk         in   system clock (same domain as the controller)
//  rst         in   asynchronous reset, active-low
//  sys         if   syscall link, slave side (sysc_mp/sys_op/sys_inf_out in,
//                   cpu_slep/cpu_wake/sys_inf_in out)
//  sw          in   32 board switches, asynchronous
//  key_raw     in   confirm key, raw, asynchronous, active-high
//  disp_data   out  last printed word
//  disp_valid  out  disp_data holds a printed word
//  busy        out  FSM is not in IDLE
//  exit_flag   out  sticky, set by EXIT
//  err_flag    out  sticky, set by an unknown op or a request while busy
//  state_dbg   out  current FSM state (ST_* encodings)
module syscall_handler
    import syscall_handler_pkg::*;
#(
    parameter int          OP_W        = SYS_OP_LENGTH,
    parameter int unsigned HOLD_CYCLES = 4096,
    parameter int unsigned DEB_CYCLES  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    syscall_handler_if.slave sys,
    input  logic [31:0]      sw,
    input  logic             key_raw,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic             busy,
    output logic             exit_flag,
    output logic             err_flag,
    output state_t           state_dbg
);
    localparam int unsigned HOLD_LOAD = hold_load(HOLD_CYCLES);
    localparam int          HOLD_W    = (HOLD_LOAD > 0) ? $clog2(HOLD_LOAD + 1) : 1;

    state_t          state;
    logic [OP_W-1:0] op_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic            slep_q;
    logic            wake_q;
    logic [31:0]     rdata_q;
    logic [31:0]     sw_s1;
    logic [31:0]     sw_s2;
    logic            key_db;
    logic            key_db_q;
    logic            key_rise;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
        .clk (clk),
        .rst (rst),
        .in  (key_raw),
        .out (key_db)
    );

    // The edge detector runs in every state. A key that is already held when
    // READ_WAIT is entered produces no rise, so the user must press it again.
    assign key_rise = key_db & ~key_db_q;

    assign sys.cpu_slep   = slep_q;
    assign sys.cpu_wake   = wake_q;
    assign sys.sys_inf_in = rdata_q;
    assign busy           = (state != ST_IDLE);
    assign state_dbg      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            hold_cnt   <= '0;
            slep_q     <= 1'b0;
            wake_q     <= 1'b0;
            rdata_q    <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            key_db_q   <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            exit_flag  <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            // slep_q and wake_q are one-cycle pulses. They are set only on the
            // transitions into SLEEP and into WAKE, so they can never be high together.
            slep_q   <= 1'b0;
            wake_q   <= 1'b0;
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            key_db_q <= key_db;

            case (state)
                ST_IDLE: begin
                    if (sys.sysc_mp) begin
                        op_q   <= sys.sys_op;
                        slep_q <= 1'b1;
                        state  <= ST_SLEEP;
                        if (sys.sys_op == OP_W'(SYS_OP_PRINT)) begin
                            disp_data  <= sys.sys_inf_out;
                            disp_valid <= 1'b1;
                        end
                    end
                end
                ST_SLEEP: begin
                    if (op_q == OP_W'(SYS_OP_PRINT)) begin
                        hold_cnt <= HOLD_W'(HOLD_LOAD);
                        state    <= ST_PRINT_HOLD;
                    end else if (op_q == OP_W'(SYS_OP_READ)) begin
                        state <= ST_READ_WAIT;
                    end else if (op_q == OP_W'(SYS_OP_EXIT)) begin
                        exit_flag <= 1'b1;
                        state     <= ST_HALTED;
                    end else begin
                        err_flag <= 1'b1;
                        wake_q   <= 1'b1;
                        state    <= ST_WAKE;
                    end
                end
                ST_PRINT_HOLD: begin
                    if (hold_cnt == '0) begin
                        wake_q <= 1'b1;
                        state  <= ST_WAKE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_READ_WAIT: begin
                    if (key_rise) begin
                        rdata_q <= sw_s2;
                        wake_q  <= 1'b1;
                        state   <= ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    state <= ST_IDLE;
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A request while busy is dropped. The FSM state and the latched op are left
            // untouched.
            if (sys.sysc_mp && (state != ST_IDLE)) begin
                err_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_syscall_handler.sv
// Self-checking bench for syscall_handler (HOLD_CYCLES=4, DEB_CYCLES=3).
// The reference model predicts, for each request:
//  - the cycle of the sleep pulse and of the wake pulse,
//  - the display, read-data and flag state after the request.
// A monitor checks every observed pulse against the expected queues.
module tb_syscall_handler;
    import syscall_handler_pkg::*;

    localparam int          HOLD = 4;
    localparam int          DEB  = 3;
    localparam logic [31:0] ANY  = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    syscall_handler_if #(.OP_W(4)) sys_bus ();
    logic [31:0] sw;
    logic        key_raw;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        busy;
    logic        exit_flag;
    logic        err_flag;
    logic [2:0]  state_dbg;

    syscall_handler #(
        .OP_W        (4),
        .HOLD_CYCLES (HOLD),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sys        (sys_bus.slave),
        .sw         (sw),
        .key_raw    (key_raw),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy),
        .exit_flag  (exit_flag),
        .err_flag   (err_flag),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_slep_q[$];
    logic [31:0] exp_wake_q[$];

    // model state
    logic [31:0] m_disp;
    logic        m_disp_valid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        m_exit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_disp       = '0;
        m_disp_valid = 1'b0;
        m_rdata      = '0;
        m_err        = 1'b0;
        m_exit       = 1'b0;
        exp_slep_q.delete();
        exp_wake_q.delete();
    endtask

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (sys_bus.cpu_slep && sys_bus.cpu_wake) check("slep_wake_overlap", 1, 0);
            if (sys_bus.cpu_slep) begin
                if (exp_slep_q.size() == 0) check("slep_unexpected", cyc, ANY);
                else check("slep_cycle", cyc, exp_slep_q.pop_front());
            end
            if (sys_bus.cpu_wake) begin
                if (exp_wake_q.size() == 0) begin
                    check("wake_unexpected", cyc, ANY);
                end else begin
                    logic [31:0] e;
                    e = exp_wake_q.pop_front();
                    if (e != ANY) check("wake_cycle", cyc, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue a one-cycle request. c0 is the cycle index of the window just after edge E0.
    task automatic syscall(input logic [3:0] op, input logic [31:0] data, output int unsigned c0);
        @(negedge clk);
        sys_bus.sysc_mp     = 1'b1;
        sys_bus.sys_op      = op;
        sys_bus.sys_inf_out = data;
        @(posedge clk);
        #1;
        sys_bus.sysc_mp     = 1'b0;
        sys_bus.sys_op      = 4'($urandom);
        sys_bus.sys_inf_out = $urandom;
        c0 = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        check(tag, busy, 0);
    endtask

    // Optional bounce (alternating 1/0, one cycle each), then hold 10 cycles, then release.
    task automatic press_key(input int bounce);
        for (int i = 0; i < bounce; i++) begin
            @(negedge clk);
            key_raw = ~i[0];
        end
        key_raw = 1'b1;
        repeat (10) @(negedge clk);
        key_raw = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_slep_missing"}, 32'(exp_slep_q.size()), 0);
        check({tag, "_wake_missing"}, 32'(exp_wake_q.size()), 0);
        check({tag, "_disp_data"}, disp_data, m_disp);
        check({tag, "_disp_valid"}, disp_valid, m_disp_valid);
        check({tag, "_sys_inf_in"}, sys_bus.sys_inf_in, m_rdata);
        check({tag, "_err_flag"}, err_flag, m_err);
        check({tag, "_exit_flag"}, exit_flag, m_exit);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_disp_data"}, disp_data, 0);
        check({tag, "_disp_valid"}, disp_valid, 0);
        check({tag, "_sys_inf_in"}, sys_bus.sys_inf_in, 0);
        check({tag, "_slep"}, sys_bus.cpu_slep, 0);
        check({tag, "_wake"}, sys_bus.cpu_wake, 0);
        check({tag, "_err"}, err_flag, 0);
        check({tag, "_exit"}, exit_flag, 0);
    endtask

    // Assert reset mid-cycle, check outputs clear immediately, then release.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all_zero(tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_print(input string tag, input logic [31:0] data);
        int unsigned c0;
        syscall(SYS_OP_PRINT, data, c0);
        exp_slep_q.push_back(c0);
        exp_wake_q.push_back(c0 + 1 + HOLD);
        m_disp       = data;
        m_disp_valid = 1'b1;
        @(negedge clk);
        check({tag, "_disp_early"}, disp_data, data);
        wait_idle({tag, "_idle"}, 40);
        end_checks(tag);
    endtask

    task automatic do_read(input string tag, input logic [31:0] swv, input int bounce);
        int unsigned c0;
        sw = swv;
        syscall(SYS_OP_READ, $urandom, c0);
        exp_slep_q.push_back(c0);
        exp_wake_q.push_back(ANY);
        repeat (3) @(negedge clk);
        check({tag, "_waiting"}, busy, 1);
        press_key(bounce);
        m_rdata = swv;
        wait_idle({tag, "_idle"}, 40);
        sw = $urandom;
        end_checks(tag);
    endtask

    task automatic do_unknown(input string tag, input logic [3:0] op);
        int unsigned c0;
        syscall(op, $urandom, c0);
        exp_slep_q.push_back(c0);
        exp_wake_q.push_back(c0 + 1);
        m_err = 1'b1;
        wait_idle({tag, "_idle"}, 20);
        end_checks(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int unsigned c0;
        sys_bus.sysc_mp     = 1'b0;
        sys_bus.sys_op      = '0;
        sys_bus.sys_inf_out = '0;
        sw                  = '0;
        key_raw             = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // directed PRINT / READ / unknown
        do_print("print_dead", 32'hDEAD_BEEF);
        do_read("read_a5a5", 32'h0000_A5A5, 2);
        do_unknown("unk7", 4'd7);

        // a key already held before READ_WAIT is entered does not count
        key_raw = 1'b1;
        repeat (10) @(negedge clk);
        sw = 32'h1234_5678;
        syscall(SYS_OP_READ, 0, c0);
        exp_slep_q.push_back(c0);
        exp_wake_q.push_back(ANY);
        repeat (20) @(negedge clk);
        check("stale_key_ignored", busy, 1);
        key_raw = 1'b0;
        repeat (10) @(negedge clk);
        press_key(0);
        m_rdata = 32'h1234_5678;
        wait_idle("stale_key_idle", 40);
        end_checks("stale_key");

        // randomized mix
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 2))
                0: do_print("rnd_print", $urandom);
                1: do_read("rnd_read", $urandom, $urandom_range(0, 2));
                default: begin
                    logic [3:0] op;
                    op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(4, 15));
                    do_unknown("rnd_unk", op);
                end
            endcase
        end

        // request during PRINT_HOLD: dropped, error flagged, timing unchanged
        pulse_reset("rst_clean");
        syscall(SYS_OP_PRINT, 32'h1111_1111, c0);
        exp_slep_q.push_back(c0);
        exp_wake_q.push_back(c0 + 1 + HOLD);
        m_disp       = 32'h1111_1111;
        m_disp_valid = 1'b1;
        @(negedge clk);
        begin
            int unsigned c1;
            syscall(SYS_OP_PRINT, 32'h2222_2222, c1);
            check("collide_in_hold", busy, 1);
        end
        m_err = 1'b1;
        check("collide_disp", disp_data, 32'h1111_1111);
        wait_idle("collide_idle", 40);
        end_checks("collide");

        // reset in READ_WAIT aborts without a wake; the next PRINT is served normally
        sw = 32'h0BAD_F00D;
        syscall(SYS_OP_READ, 0, c0);
        exp_slep_q.push_back(c0);
        exp_wake_q.push_back(ANY);
        repeat (4) @(negedge clk);
        check("rst_in_read_busy", busy, 1);
        pulse_reset("rst_in_read");
        repeat (10) @(negedge clk);
        do_print("after_rst", 32'hC0FF_EE01);

        // EXIT: one sleep, no wake ever, a later request only sets err_flag
        syscall(SYS_OP_EXIT, $urandom, c0);
        exp_slep_q.push_back(c0);
        m_exit = 1'b1;
        repeat (100) @(negedge clk);
        check("exit_busy", busy, 1);
        end_checks("exit");
        syscall(SYS_OP_PRINT, 32'hCAFE_0000, c0);
        m_err = 1'b1;
        repeat (20) @(negedge clk);
        check("halted_busy", busy, 1);
        end_checks("halted_req");

        // reset leaves HALTED; service resumes
        pulse_reset("rst_halted");
        do_print("final_print", 32'h5A5A_0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
